// File: rtl/beat_pack4.sv
// beat_pack4: packs four WIDTH-bit beats into one O0..O3 frame
// for a downstream 4-input XNOR stage, with valid/ready on both sides.
module beat_pack4 #(
  parameter int WIDTH = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [1:0]       FILL
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [WIDTH-1:0] slot2;
  logic             in_xfer;
  logic             out_xfer;
  logic             done;

  // Only a completing beat needs the output register, so only it
  // waits on a stalled frame; beats 1..3 keep flowing.
  assign I_READY  = !RESET &&
                    !((FILL == 2'd3) && O_VALID && !O_READY);
  assign in_xfer  = I_VALID && I_READY;
  assign out_xfer = O_VALID && O_READY;
  assign done     = in_xfer && (FILL == 2'd3);

  // Assembly buffer and output register; a completing beat
  // overwrites a draining frame on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      slot0   <= '0;
      slot1   <= '0;
      slot2   <= '0;
      FILL    <= 2'd0;
      O0      <= '0;
      O1      <= '0;
      O2      <= '0;
      O3      <= '0;
      O_VALID <= 1'b0;
    end else begin
      if (in_xfer) begin
        case (FILL)
          2'd0:    slot0 <= I;
          2'd1:    slot1 <= I;
          2'd2:    slot2 <= I;
          default: ;
        endcase
        FILL <= done ? 2'd0 : FILL + 2'd1;
      end
      if (done) begin
        O0      <= slot0;
        O1      <= slot1;
        O2      <= slot2;
        O3      <= I;
        O_VALID <= 1'b1;
      end else if (out_xfer) begin
        O_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_beat_pack4.sv
// tb_beat_pack4: random and directed stimulus, queue-based
// reference model, scoreboard monitor on the output handshake.
module tb_beat_pack4;

  localparam int W = 2;
  typedef logic [4*W-1:0] frame_t;

  logic         CLK;
  logic         RESET;
  logic [W-1:0] I;
  logic         I_VALID;
  logic         I_READY;
  logic [W-1:0] O0, O1, O2, O3;
  logic         O_VALID;
  logic         O_READY;
  logic [1:0]   FILL;

  beat_pack4 #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .I(I), .I_VALID(I_VALID),
    .I_READY(I_READY), .O0(O0), .O1(O1), .O2(O2), .O3(O3),
    .O_VALID(O_VALID), .O_READY(O_READY), .FILL(FILL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [W-1:0] part[$];
  bit           held;
  frame_t       disp;
  frame_t       exp_q[$];
  bit           chk_en = 0;
  bit           exp_ready;
  bit           exp_valid;
  int           exp_fill;

  task automatic check(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, act, exp, $time);
    end
  endtask

  // Scoreboard: compare displayed frame with the oldest expected one.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("i_ready", {31'd0, I_READY}, {31'd0, exp_ready});
      check("fill", {30'd0, FILL}, exp_fill);
      check("o_valid", {31'd0, O_VALID}, {31'd0, exp_valid});
      if (O_VALID) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL frame_q: O_VALID=1 but no frame expected");
        end else begin
          check("frame", {24'd0, O0, O1, O2, O3}, {24'd0, exp_q[0]});
          if (O_READY) void'(exp_q.pop_front());
        end
      end else begin
        check("held_frame", {24'd0, O0, O1, O2, O3}, {24'd0, disp});
      end
    end
  end

  // One cycle: drive at posedge+1, predict, then apply model at next edge.
  task automatic cyc(input bit rst, input bit iv,
                     input logic [W-1:0] d, input bit ordy);
    bit acc, drain;
    RESET   = rst;
    I_VALID = iv;
    I       = d;
    O_READY = ordy;
    exp_fill  = part.size();
    exp_valid = held;
    exp_ready = !rst && !(part.size() == 3 && held && !ordy);
    acc   = iv && exp_ready;
    drain = held && ordy;
    @(posedge CLK);
    #1;
    if (rst) begin
      part.delete();
      exp_q.delete();
      held   = 0;
      disp   = '0;
      chk_en = 1;
    end else begin
      if (drain) held = 0;
      if (acc) begin
        if (part.size() == 3) begin
          disp = {part[0], part[1], part[2], d};
          exp_q.push_back(disp);
          part.delete();
          held = 1;
        end else begin
          part.push_back(d);
        end
      end
    end
  endtask

  logic [W-1:0] xn;

  initial begin
    RESET = 1'b1; I_VALID = 1'b0; I = '0; O_READY = 1'b0;
    held = 0; disp = '0;
    @(posedge CLK);
    #1;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // basic pack 1,2,3,0
    cyc(0, 1, 2'd1, 1); cyc(0, 1, 2'd2, 1);
    cyc(0, 1, 2'd3, 1); cyc(0, 1, 2'd0, 1);
    xn = ~(O0 ^ O1 ^ O2 ^ O3);
    check("xnor", {30'd0, xn}, 32'h3);
    cyc(0, 0, 0, 1);
    // backpressure: stalled frame then 7 more beats
    for (int k = 0; k < 4; k++) cyc(0, 1, W'(k), 0);
    for (int k = 0; k < 7; k++) cyc(0, 1, W'(3 - k % 4), 0);
    cyc(0, 1, 2'd2, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    // back-to-back streaming
    for (int k = 0; k < 16; k++) cyc(0, 1, W'(k % 4), 1);
    cyc(0, 0, 0, 1);
    // gapped input
    for (int k = 0; k < 8; k++) cyc(0, (k % 2) == 0, 2'd3, 1);
    cyc(0, 0, 0, 1);
    // reset mid-frame
    cyc(0, 1, 2'd2, 1); cyc(0, 1, 2'd2, 1);
    cyc(1, 0, 0, 1);
    check("rst_o", {24'd0, O0, O1, O2, O3}, 32'h0);
    cyc(0, 1, 2'd1, 1); cyc(0, 1, 2'd0, 1);
    cyc(0, 1, 2'd0, 1); cyc(0, 1, 2'd1, 1);
    cyc(0, 0, 0, 1);
    // reset with a stalled frame and FILL=2
    for (int k = 0; k < 6; k++) cyc(0, 1, W'(k + 1), 0);
    cyc(1, 1, 2'd3, 0);
    check("rst_valid", {31'd0, O_VALID}, 32'h0);
    check("rst_fill", {30'd0, FILL}, 32'h0);
    cyc(0, 0, 0, 0);
    // randomized traffic
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 9) < 7,
          W'($urandom_range(0, 3)),
          $urandom_range(0, 9) < 6);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
